seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux_if.sv | 36 +++
 rtl/seg_scan_mux.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit code inputs and scanned display outputs of seg_scan_mux
// blink_mask exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_mux_if;
    logic       en;
    logic [6:0] sig_digi0;
    logic [6:0] sig_digi1;
    logic [6:0] sig_digi2;
    logic [6:0] minute_digi0;
    logic [6:0] minute_digi1;
    logic [6:0] hour_digi0;
    logic [6:0] hour_digi1;
`ifdef SEG_SCAN_BLINK_EN
    logic [6:0] blink_mask;
`endif
    logic [6:0] seg;
    logic [6:0] dig_sel;
    logic       frame_done;

    modport master (
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask,
`endif
        output en, sig_digi0, sig_digi1, sig_digi2,
        output minute_digi0, minute_digi1, hour_digi0, hour_digi1,
        input  seg, dig_sel, frame_done
    );

    modport slave (
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask,
`endif
        input  en, sig_digi0, sig_digi1, sig_digi2,
        input  minute_digi0, minute_digi1, hour_digi0, hour_digi1,
        output seg, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed 7-digit 7-segment scanner with blanking gaps
// Optional digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_mux #(
    parameter int DWELL        = 1000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         rst,
    seg_scan_mux_if.slave bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    if (DWELL < 1 || BLANK < 1 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("seg_scan_mux: DWELL, BLANK and BLINK_FRAMES must be at least 1");
    end

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t        state, state_d;
    logic [2:0]    idx, idx_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          wrap;
    logic          snap_now;
    logic [6:0]    snap [7];
    logic [6:0]    code_live, code_snap;
    logic [6:0]    seg_d, dig_sel_d;
    logic          blink_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_BLANK;
            idx            <= 3'd0;
            cnt            <= '0;
            bus.seg        <= 7'd0;
            bus.dig_sel    <= 7'd0;
            bus.frame_done <= 1'b0;
            for (int i = 0; i < 7; i++) snap[i] <= 7'd0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
            bus.seg        <= seg_d;
            bus.dig_sel    <= dig_sel_d;
            bus.frame_done <= wrap;
            if (snap_now) begin
                snap[0] <= bus.sig_digi0;
                snap[1] <= bus.sig_digi1;
                snap[2] <= bus.sig_digi2;
                snap[3] <= bus.minute_digi0;
                snap[4] <= bus.minute_digi1;
                snap[5] <= bus.hour_digi0;
                snap[6] <= bus.hour_digi1;
            end
        end
    end

    // en low overrides any phase-end advance on the same edge.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        wrap     = 1'b0;
        snap_now = 1'b0;
        if (!bus.en) begin
            state_d = S_BLANK;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state)
                S_BLANK: begin
                    if (cnt == CW'(BLANK - 1)) begin
                        state_d  = S_SHOW;
                        cnt_d    = '0;
                        snap_now = (idx == 3'd0);
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt == CW'(DWELL - 1)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx == 3'd6) begin
                            idx_d = 3'd0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        code_live = 7'd0;
        code_snap = 7'd0;
        case (idx_d)
            3'd0: begin code_live = bus.sig_digi0;    code_snap = snap[0]; end
            3'd1: begin code_live = bus.sig_digi1;    code_snap = snap[1]; end
            3'd2: begin code_live = bus.sig_digi2;    code_snap = snap[2]; end
            3'd3: begin code_live = bus.minute_digi0; code_snap = snap[3]; end
            3'd4: begin code_live = bus.minute_digi1; code_snap = snap[4]; end
            3'd5: begin code_live = bus.hour_digi0;   code_snap = snap[5]; end
            3'd6: begin code_live = bus.hour_digi1;   code_snap = snap[6]; end
            default: ;
        endcase
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt;
    logic          phase;
    logic [6:0]    mask_q;
    logic [6:0]    mask_now;

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            fcnt   <= '0;
            phase  <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
        if (rst) begin
            mask_q <= 7'd0;
        end else if (snap_now) begin
            mask_q <= bus.blink_mask;
        end
    end

    always_comb begin
        mask_now  = snap_now ? bus.blink_mask : mask_q;
        blink_off = phase && mask_now[idx_d];
    end
`else
    always_comb blink_off = 1'b0;
`endif

    // idx 0 shows the live inputs on the snapshot edge so there is no extra frame of latency.
    always_comb begin
        seg_d     = 7'd0;
        dig_sel_d = 7'd0;
        if (state_d == S_SHOW) begin
            dig_sel_d = 7'(1) << idx_d;
            if (!blink_off) seg_d = snap_now ? code_live : code_snap;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed table-driven bench for seg_scan_mux (DWELL=4, BLANK=2)
// Blink sequence runs only when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_mux;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 7 * SLOT;

    logic clk;
    logic rst;

    seg_scan_mux_if bus();

    seg_scan_mux #(.DWELL(DWELL), .BLANK(BLANK), .BLINK_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic show;
        int   idx;
        logic fd;
    } vec_t;

    vec_t       vec [FRAME];
    logic [6:0] exp_code [7];
    logic [6:0] blink_exp_mask;
    logic       blink_on;
    int         n_checks;
    int         n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [6:0] es, input logic [6:0] ed,
                             input logic ef);
        n_checks += 3;
        if (bus.seg !== es) begin
            n_fail++;
            $display("FAIL %s seg got %h want %h", name, bus.seg, es);
        end
        if (bus.dig_sel !== ed) begin
            n_fail++;
            $display("FAIL %s dig_sel got %b want %b", name, bus.dig_sel, ed);
        end
        if (bus.frame_done !== ef) begin
            n_fail++;
            $display("FAIL %s frame_done got %b want %b", name, bus.frame_done, ef);
        end
    endtask

    task automatic check_pos(input string name, input int p);
        logic [6:0] es, ed;
        es = 7'd0;
        ed = 7'd0;
        if (vec[p].show) begin
            ed = 7'(1) << vec[p].idx;
            if (!(blink_on && blink_exp_mask[vec[p].idx])) es = exp_code[vec[p].idx];
        end
        check_out($sformatf("%s_p%0d", name, p), es, ed, vec[p].fd);
    endtask

    task automatic drive_codes();
        bus.sig_digi0    = exp_code[0];
        bus.sig_digi1    = exp_code[1];
        bus.sig_digi2    = exp_code[2];
        bus.minute_digi0 = exp_code[3];
        bus.minute_digi1 = exp_code[4];
        bus.hour_digi0   = exp_code[5];
        bus.hour_digi1   = exp_code[6];
    endtask

    initial begin
        // Position p in a frame: slot p/SLOT, first BLANK cycles dark, then digit lit.
        for (int p = 0; p < FRAME; p++) begin
            vec[p].show = (p % SLOT) >= BLANK;
            vec[p].idx  = p / SLOT;
            vec[p].fd   = (p == 0);
        end
        for (int i = 0; i < 7; i++) exp_code[i] = 7'(i + 1);
        blink_exp_mask = 7'b1100000;
        blink_on       = 1'b0;
        n_checks       = 0;
        n_fail         = 0;

        rst    = 1'b1;
        bus.en = 1'b1;
        bus.sig_digi0    = 7'($urandom);
        bus.sig_digi1    = 7'($urandom);
        bus.sig_digi2    = 7'($urandom);
        bus.minute_digi0 = 7'($urandom);
        bus.minute_digi1 = 7'($urandom);
        bus.hour_digi0   = 7'($urandom);
        bus.hour_digi1   = 7'($urandom);
`ifdef SEG_SCAN_BLINK_EN
        bus.blink_mask = 7'b1100000;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("reset%0d", i), 7'd0, 7'd0, 1'b0);
        end

        // Basic scan over two frames; the first frame has no frame_done.
        drive_codes();
        rst = 1'b0;
        check_out("release", 7'd0, 7'd0, 1'b0);
        for (int n = 1; n < 2 * FRAME; n++) begin
            tick();
            check_pos("scan", n % FRAME);
        end

        // Snapshot coherence: idx 6 input changes while idx 2 is lit.
        bus.hour_digi1 = 7'h3F;
        exp_code[6]    = 7'h3F;
        for (int p = 0; p < FRAME; p++) begin
            tick();
            check_pos("snapA", p);
            if (p == 2 * SLOT + BLANK) bus.hour_digi1 = 7'h06;
        end
        exp_code[6] = 7'h06;
        for (int p = 0; p < FRAME; p++) begin
            tick();
            check_pos("snapB", p);
        end

        // Enable abort on the 2nd lit cycle of idx 3.
        for (int p = 0; p <= 3 * SLOT + BLANK + 1; p++) begin
            tick();
            check_pos("pre_abort", p);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("en_low%0d", i), 7'd0, 7'd0, 1'b0);
        end
        bus.en = 1'b1;
        tick();
        check_out("reen_blank", 7'd0, 7'd0, 1'b0);
        for (int p = BLANK; p < FRAME; p++) begin
            tick();
            check_pos("reen", p);
        end
        tick();
        check_pos("reen_done", 0);

        // Mid-frame reset during idx 4: restart without frame_done for the aborted frame.
        for (int p = 1; p <= 4 * SLOT + BLANK; p++) begin
            tick();
            check_pos("pre_rst", p);
        end
        rst = 1'b1;
        tick();
        check_out("rst_mid", 7'd0, 7'd0, 1'b0);
        rst = 1'b0;
        check_out("rst_rel", 7'd0, 7'd0, 1'b0);
        for (int p = 1; p < FRAME; p++) begin
            tick();
            check_pos("post_rst", p);
        end
        tick();
        check_pos("post_rst_done", 0);

`ifdef SEG_SCAN_BLINK_EN
        // Blink half-period of 2 frames: frames 2 and 3 dark on idx 5 and 6.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            blink_on = (f == 2) || (f == 3);
            for (int p = 0; p < FRAME; p++) begin
                if (f == 0 && p == 0) begin
                    check_out("blink_start", 7'd0, 7'd0, 1'b0);
                end else begin
                    tick();
                    check_pos($sformatf("blink_f%0d", f), p);
                end
            end
        end
        blink_on = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
